hub75_fb_writer: RTL and testbench
==================================

Name: hub75_fb_writer

Overview:
Upstream feeder for the HUB75 top block. Accepts a raster pixel stream with valid/ready handshake and start-of-frame marker, fills the framebuffer line buffer, and issues row store/swap commands. At end of frame it requests the front/back frame swap and stalls the stream until the swap is taken. Sits between the video source (pattern generator, SPI/USB loader) and the fbw_*/frame_* interface.

Parameters:
N_BANKS, 2, parallel readout banks (power of 2, >=2)
N_ROWS, 32, rows per bank (power of 2)
N_COLS, 64, columns per line (power of 2)
BITDEPTH, 24, bits per input pixel
LOG_N_BANKS / LOG_N_ROWS / LOG_N_COLS, $clog2 of the above, auto-set

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
s_data  in  BITDEPTH  pixel data
s_sof  in  1  marks first pixel of a frame, qualified by s_valid
s_valid  in  1  pixel valid
s_ready  out  1  pixel accepted when s_valid & s_ready
fbw_bank_addr  out  LOG_N_BANKS  bank of row being stored
fbw_row_addr  out  LOG_N_ROWS  row being stored
fbw_row_store  out  1  one-cycle store pulse
fbw_row_rdy  in  1  framebuffer can accept a store
fbw_row_swap  out  1  one-cycle line buffer swap pulse
fbw_data  out  BITDEPTH  line buffer write data
fbw_col_addr  out  LOG_N_COLS  line buffer write column
fbw_wren  out  1  line buffer write enable
frame_swap  out  1  one-cycle frame swap request
frame_rdy  in  1  no frame swap pending
stat_frame_done  out  1  one-cycle pulse when frame_swap issued
stat_resync  out  1  one-cycle pulse on mid-frame s_sof

Behaviour:
- All outputs registered except s_ready (decoded from state). Reset: all outputs 0, counters 0, state LOAD.
- Counters: col (LOG_N_COLS), line (LOG_N_BANKS+LOG_N_ROWS); bank = line MSBs, row = line LSBs (line = bank*N_ROWS + row).
- LOAD: s_ready=1. On accept: fbw_wren=1, fbw_data=s_data, fbw_col_addr=col the next cycle (1-cycle write latency); col++. Accept at col=N_COLS-1 -> latch bank/row of current line, col wraps to 0, go STORE.
- STORE: s_ready=0. When fbw_row_rdy=1: pulse fbw_row_swap and fbw_row_store together for 1 cycle, fbw_bank_addr/fbw_row_addr held until the next store. Last line (line = N_BANKS*N_ROWS-1) -> FSWAP, line wraps to 0; else line++, back to LOAD. The registered final write always lands before the swap pulse (STORE lasts >=1 cycle).
- FSWAP: s_ready=0. When frame_rdy=1: pulse frame_swap and stat_frame_done, go FWAIT.
- FWAIT: s_ready=0. frame_rdy is low from the cycle after the pulse. Return to LOAD when frame_rdy=1 is sampled at least 1 cycle after the pulse. This protects the back buffer while the swap is pending.
- SOF rules:
  - Accepted pixel with s_sof at line=0, col=0: normal.
  - Accepted pixel with s_sof elsewhere in LOAD: resync. That pixel is written at col 0, col=1, line=0, stat_resync pulses. The partial line buffer is overwritten, and no store is issued for the partial line.
  - Pixel without s_sof at line=0, col=0: accepted (free-running source).
- fbw_row_rdy or frame_rdy held low: block stalls indefinitely with s_ready=0, no pulses emitted.
- Async reset mid-operation: immediate return to reset values. Any pending pulse is dropped, and the next accepted pixel is line 0, col 0.

Decomposition:
- Shared package hub75_fbw_pkg: state encoding (LOAD, STORE, FSWAP, FWAIT) and derived widths/last-line constant.
- One natural sub-module: hub75_fbw_addrgen, the col/line counters with wrap and resync-load, outputting bank/row/col and last_col/last_line flags.

Test Plan:
- N_COLS=64, 2x32: stream 4096 pixels, s_sof on first, fbw_row_rdy=frame_rdy=1 -> 64 fbw_row_store pulses with rows 0..31 bank 0, then 0..31 bank 1; 1 frame_swap after the last store.
- Pixel p (value 0xA5A5A5) accepted at col 17 -> next cycle fbw_wren=1, fbw_col_addr=17, fbw_data=0xA5A5A5.
- Hold fbw_row_rdy=0 for 20 cycles after col 63 -> s_ready=0 for 20 cycles, no store. Release -> store+swap in the same cycle, then s_ready=1.
- Hold frame_rdy=0 at frame end for 50 cycles -> no frame_swap. Release -> 1 frame_swap pulse. Then force frame_rdy=0 for 10 cycles -> s_ready stays 0 until frame_rdy=1.
- s_sof at line 5, col 30 -> stat_resync pulse, write at col 0. The next store after 64 pixels is bank 0 row 0.
- Assert rst during STORE with fbw_row_rdy=0 -> all outputs 0. The first pixel after release writes col 0, and the first store is row 0.

Source files
------------

// File: rtl/hub75_fbw_pkg.sv
// hub75_fbw_pkg
//   Shared definitions for the HUB75 framebuffer writer.
//   - fbw_state_t   : writer FSM states (LOAD, STORE, FSWAP, FWAIT)
//   - fbw_line_w()  : width of the combined bank/row line counter
//   - fbw_last_line(): index of the last line in a frame
package hub75_fbw_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_STORE = 2'd1,
    ST_FSWAP = 2'd2,
    ST_FWAIT = 2'd3
  } fbw_state_t;

  function automatic int unsigned fbw_line_w(input int unsigned n_banks,
                                             input int unsigned n_rows);
    return $clog2(n_banks) + $clog2(n_rows);
  endfunction

  function automatic int unsigned fbw_last_line(input int unsigned n_banks,
                                                input int unsigned n_rows);
    return n_banks * n_rows - 1;
  endfunction

endpackage

// File: rtl/hub75_fbw_addrgen.sv
// hub75_fbw_addrgen
//   Column and line counters for the framebuffer writer.
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     col_inc       : advance column (wraps to 0 after N_COLS-1)
//     line_inc      : advance line (wraps to 0 after the last line)
//     resync        : load col=1, line=0 (pixel being written at col 0)
//     col/bank/row  : current write position
//     last_col      : col == N_COLS-1
//     last_line     : line == N_BANKS*N_ROWS-1
//     at_origin     : line == 0 and col == 0
module hub75_fbw_addrgen
  import hub75_fbw_pkg::*;
#(
  parameter int unsigned N_BANKS     = 2,
  parameter int unsigned N_ROWS      = 32,
  parameter int unsigned N_COLS      = 64,
  parameter int unsigned LOG_N_BANKS = $clog2(N_BANKS),
  parameter int unsigned LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int unsigned LOG_N_COLS  = $clog2(N_COLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   col_inc,
  input  logic                   line_inc,
  input  logic                   resync,
  output logic [LOG_N_COLS-1:0]  col,
  output logic [LOG_N_BANKS-1:0] bank,
  output logic [LOG_N_ROWS-1:0]  row,
  output logic                   last_col,
  output logic                   last_line,
  output logic                   at_origin
);

  localparam int unsigned LINE_W = LOG_N_BANKS + LOG_N_ROWS;

  logic [LINE_W-1:0] line;

  // Power-of-two sizes: natural counter overflow provides the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col  <= '0;
      line <= '0;
    end else if (resync) begin
      col  <= LOG_N_COLS'(1);
      line <= '0;
    end else begin
      if (col_inc)
        col <= col + LOG_N_COLS'(1);
      if (line_inc)
        line <= line + LINE_W'(1);
    end
  end

  always_comb begin
    bank      = line[LINE_W-1 -: LOG_N_BANKS];
    row       = line[LOG_N_ROWS-1:0];
    last_col  = (col == '1);
    last_line = (line == LINE_W'(fbw_last_line(N_BANKS, N_ROWS)));
    at_origin = (col == '0) && (line == '0);
  end

endmodule

// File: rtl/hub75_fb_writer.sv
// hub75_fb_writer
//   Accepts a raster pixel stream (valid/ready + start-of-frame), writes it
//   into the framebuffer line buffer, issues row store/swap commands and a
//   frame swap request at end of frame.
//   Ports:
//     clk, rst                       : clock, asynchronous active-high reset
//     s_data/s_sof/s_valid/s_ready   : pixel stream input
//     fbw_bank_addr/fbw_row_addr     : destination of the current row store
//     fbw_row_store/fbw_row_swap     : one-cycle store + line buffer swap
//     fbw_row_rdy                    : framebuffer can accept a store
//     fbw_data/fbw_col_addr/fbw_wren : line buffer write port
//     frame_swap/frame_rdy           : frame swap request / no swap pending
//     stat_frame_done/stat_resync    : status pulses
module hub75_fb_writer
  import hub75_fbw_pkg::*;
#(
  parameter int unsigned N_BANKS     = 2,
  parameter int unsigned N_ROWS      = 32,
  parameter int unsigned N_COLS      = 64,
  parameter int unsigned BITDEPTH    = 24,
  parameter int unsigned LOG_N_BANKS = $clog2(N_BANKS),
  parameter int unsigned LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int unsigned LOG_N_COLS  = $clog2(N_COLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BITDEPTH-1:0]    s_data,
  input  logic                   s_sof,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [LOG_N_BANKS-1:0] fbw_bank_addr,
  output logic [LOG_N_ROWS-1:0]  fbw_row_addr,
  output logic                   fbw_row_store,
  input  logic                   fbw_row_rdy,
  output logic                   fbw_row_swap,
  output logic [BITDEPTH-1:0]    fbw_data,
  output logic [LOG_N_COLS-1:0]  fbw_col_addr,
  output logic                   fbw_wren,
  output logic                   frame_swap,
  input  logic                   frame_rdy,
  output logic                   stat_frame_done,
  output logic                   stat_resync
);

  fbw_state_t state, state_nxt;

  logic [LOG_N_COLS-1:0]  col;
  logic [LOG_N_BANKS-1:0] bank;
  logic [LOG_N_ROWS-1:0]  row;
  logic                   last_col, last_line, at_origin;

  logic accept, resync, col_inc, store_fire, fswap_fire;

  hub75_fbw_addrgen #(
    .N_BANKS     (N_BANKS),
    .N_ROWS      (N_ROWS),
    .N_COLS      (N_COLS),
    .LOG_N_BANKS (LOG_N_BANKS),
    .LOG_N_ROWS  (LOG_N_ROWS),
    .LOG_N_COLS  (LOG_N_COLS)
  ) u_addrgen (
    .clk       (clk),
    .rst       (rst),
    .col_inc   (col_inc),
    .line_inc  (store_fire),
    .resync    (resync),
    .col       (col),
    .bank      (bank),
    .row       (row),
    .last_col  (last_col),
    .last_line (last_line),
    .at_origin (at_origin)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_LOAD;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_LOAD:  if (col_inc && last_col) state_nxt = ST_STORE;
      ST_STORE: if (fbw_row_rdy) state_nxt = last_line ? ST_FSWAP : ST_LOAD;
      ST_FSWAP: if (frame_rdy) state_nxt = ST_FWAIT;
      // frame_swap is still high in the first FWAIT cycle; frame_rdy is
      // only trusted from the cycle after the request pulse.
      ST_FWAIT: if (!frame_swap && frame_rdy) state_nxt = ST_LOAD;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  // Output decode (s_ready combinational, the rest feed output registers)
  always_comb begin
    s_ready    = (state == ST_LOAD);
    accept     = s_valid && s_ready;
    resync     = accept && s_sof && !at_origin;
    col_inc    = accept && !resync;
    store_fire = (state == ST_STORE) && fbw_row_rdy;
    fswap_fire = (state == ST_FSWAP) && frame_rdy;
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fbw_bank_addr   <= '0;
      fbw_row_addr    <= '0;
      fbw_row_store   <= 1'b0;
      fbw_row_swap    <= 1'b0;
      fbw_data        <= '0;
      fbw_col_addr    <= '0;
      fbw_wren        <= 1'b0;
      frame_swap      <= 1'b0;
      stat_frame_done <= 1'b0;
      stat_resync     <= 1'b0;
    end else begin
      fbw_wren        <= accept;
      fbw_row_store   <= store_fire;
      fbw_row_swap    <= store_fire;
      frame_swap      <= fswap_fire;
      stat_frame_done <= fswap_fire;
      stat_resync     <= resync;
      if (accept) begin
        fbw_data     <= s_data;
        fbw_col_addr <= resync ? '0 : col;
      end
      // Row address captured when the line completes, held until next store.
      if (col_inc && last_col) begin
        fbw_bank_addr <= bank;
        fbw_row_addr  <= row;
      end
    end
  end

endmodule

// File: tb/tb_hub75_fb_writer.sv
module tb_hub75_fb_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] s_data = '0;
  logic        s_sof = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [0:0]  fbw_bank_addr;
  logic [4:0]  fbw_row_addr;
  logic        fbw_row_store;
  logic        fbw_row_rdy = 1'b1;
  logic        fbw_row_swap;
  logic [23:0] fbw_data;
  logic [5:0]  fbw_col_addr;
  logic        fbw_wren;
  logic        frame_swap;
  logic        frame_rdy = 1'b1;
  logic        stat_frame_done;
  logic        stat_resync;

  hub75_fb_writer #(
    .N_BANKS  (2),
    .N_ROWS   (32),
    .N_COLS   (64),
    .BITDEPTH (24)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_data          (s_data),
    .s_sof           (s_sof),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .fbw_bank_addr   (fbw_bank_addr),
    .fbw_row_addr    (fbw_row_addr),
    .fbw_row_store   (fbw_row_store),
    .fbw_row_rdy     (fbw_row_rdy),
    .fbw_row_swap    (fbw_row_swap),
    .fbw_data        (fbw_data),
    .fbw_col_addr    (fbw_col_addr),
    .fbw_wren        (fbw_wren),
    .frame_swap      (frame_swap),
    .frame_rdy       (frame_rdy),
    .stat_frame_done (stat_frame_done),
    .stat_resync     (stat_resync)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;
  int unsigned cyc    = 0;

  // monitor state
  int unsigned store_cnt = 0;
  int unsigned fswap_cnt = 0;
  int unsigned last_store_cyc = 0;
  int unsigned fswap_cyc = 0;
  logic        chk_order = 1'b1;
  logic [0:0]  last_bank = '0;
  logic [4:0]  last_row  = '0;

  typedef struct {
    logic        valid;
    logic        sof;
    logic [23:0] data;
    logic        exp_ready;
    logic        exp_wren;
    logic [5:0]  exp_col;
    logic [23:0] exp_data;
    logic        exp_resync;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic mon();
    if (fbw_row_store || fbw_row_swap)
      chk("row_swap_with_store", {31'd0, fbw_row_swap}, {31'd0, fbw_row_store});
    if (fbw_row_store) begin
      if (chk_order)
        chk("store_order", {26'd0, fbw_bank_addr, fbw_row_addr}, store_cnt);
      store_cnt++;
      last_bank = fbw_bank_addr;
      last_row  = fbw_row_addr;
      last_store_cyc = cyc;
    end
    if (frame_swap) begin
      chk("frame_done_with_swap", {31'd0, stat_frame_done}, 32'd1);
      fswap_cnt++;
      fswap_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mon();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_sof = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    store_cnt = 0;
    fswap_cnt = 0;
    chk_order = 1'b1;
  endtask

  task automatic send(input logic [23:0] d, input logic sof);
    int unsigned n;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    n = 0;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'd0, 32'd1);
    tick();
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int unsigned errs;
    int unsigned sc0;

    vecs[0] = '{1'b1, 1'b1, 24'h000001, 1'b1, 1'b1, 6'd0, 24'h000001, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 24'h000002, 1'b1, 1'b1, 6'd1, 24'h000002, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 24'h0000FF, 1'b1, 1'b0, 6'd1, 24'h000002, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 24'hA5A5A5, 1'b1, 1'b1, 6'd0, 24'hA5A5A5, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 24'h123456, 1'b1, 1'b1, 6'd1, 24'h123456, 1'b0};

    // ---- reset state ----
    do_reset();
    chk("rst_wren",   {31'd0, fbw_wren}, 32'd0);
    chk("rst_store",  {31'd0, fbw_row_store}, 32'd0);
    chk("rst_fswap",  {31'd0, frame_swap}, 32'd0);
    chk("rst_data",   {8'd0, fbw_data}, 32'd0);
    chk("rst_ready",  {31'd0, s_ready}, 32'd1);

    // ---- table vectors: first pixels, idle gap, resync at line 0 col 2 ----
    for (int i = 0; i < 5; i++) begin
      s_valid = vecs[i].valid;
      s_sof   = vecs[i].sof;
      s_data  = vecs[i].data;
      chk("vec_ready", {31'd0, s_ready}, {31'd0, vecs[i].exp_ready});
      tick();
      chk("vec_wren",   {31'd0, fbw_wren}, {31'd0, vecs[i].exp_wren});
      chk("vec_col",    {26'd0, fbw_col_addr}, {26'd0, vecs[i].exp_col});
      chk("vec_data",   {8'd0, fbw_data}, {8'd0, vecs[i].exp_data});
      chk("vec_resync", {31'd0, stat_resync}, {31'd0, vecs[i].exp_resync});
      chk("vec_store",  {31'd0, fbw_row_store}, 32'd0);
    end
    s_valid = 1'b0;
    s_sof = 1'b0;

    // ---- full frame, free-flowing handshakes ----
    do_reset();
    fbw_row_rdy = 1'b1;
    frame_rdy = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      send((i == 17) ? 24'hA5A5A5 : 24'(i), i == 0);
      if (i == 17) begin
        chk("col17_wren", {31'd0, fbw_wren}, 32'd1);
        chk("col17_col",  {26'd0, fbw_col_addr}, 32'd17);
        chk("col17_data", {8'd0, fbw_data}, 32'hA5A5A5);
      end
    end
    for (int i = 0; i < 6; i++) tick();
    chk("frame_store_cnt", store_cnt, 32'd64);
    chk("frame_fswap_cnt", fswap_cnt, 32'd1);
    chk("fswap_after_store", {31'd0, fswap_cyc > last_store_cyc}, 32'd1);
    chk("frame_ready_after", {31'd0, s_ready}, 32'd1);

    // ---- fbw_row_rdy stall ----
    do_reset();
    fbw_row_rdy = 1'b0;
    for (int i = 0; i < 64; i++) send(24'(i), i == 0);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      if (s_ready !== 1'b0 || fbw_row_store !== 1'b0) errs++;
      tick();
    end
    chk("rowstall_quiet", errs, 32'd0);
    chk("rowstall_no_store", store_cnt, 32'd0);
    fbw_row_rdy = 1'b1;
    tick();
    chk("rowrel_store", {31'd0, fbw_row_store}, 32'd1);
    chk("rowrel_swap",  {31'd0, fbw_row_swap}, 32'd1);
    chk("rowrel_ready", {31'd0, s_ready}, 32'd1);
    chk("rowrel_addr",  {26'd0, fbw_bank_addr, fbw_row_addr}, 32'd0);

    // ---- frame_rdy stall and post-swap wait ----
    do_reset();
    frame_rdy = 1'b0;
    for (int i = 0; i < 4096; i++) send(24'(i), i == 0);
    errs = 0;
    for (int i = 0; i < 52; i++) begin
      tick();
      if (frame_swap !== 1'b0 || s_ready !== 1'b0) errs++;
    end
    chk("fstall_quiet", errs, 32'd0);
    chk("fstall_stores", store_cnt, 32'd64);
    frame_rdy = 1'b1;
    tick();
    chk("frel_fswap", {31'd0, frame_swap}, 32'd1);
    chk("frel_done",  {31'd0, stat_frame_done}, 32'd1);
    frame_rdy = 1'b0;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_ready !== 1'b0 || frame_swap !== 1'b0) errs++;
    end
    chk("fwait_hold", errs, 32'd0);
    frame_rdy = 1'b1;
    tick();
    chk("fwait_release_ready", {31'd0, s_ready}, 32'd1);
    chk("fswap_total", fswap_cnt, 32'd1);

    // ---- mid-frame resync at line 5, col 30 ----
    do_reset();
    for (int i = 0; i < 5 * 64 + 30; i++) send(24'(i), i == 0);
    sc0 = store_cnt;
    chk("pre_resync_stores", sc0, 32'd5);
    chk_order = 1'b0;
    send(24'hC0FFEE, 1'b1);
    chk("resync_pulse", {31'd0, stat_resync}, 32'd1);
    chk("resync_col",   {26'd0, fbw_col_addr}, 32'd0);
    chk("resync_data",  {8'd0, fbw_data}, 32'hC0FFEE);
    for (int i = 0; i < 62; i++) send(24'(i), 1'b0);
    tick();
    chk("resync_no_early_store", store_cnt, sc0);
    send(24'h777777, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("resync_store_cnt", store_cnt, sc0 + 1);
    chk("resync_store_addr", {26'd0, last_bank, last_row}, 32'd0);

    // ---- async reset during STORE ----
    do_reset();
    for (int i = 0; i < 64; i++) send(24'(i), i == 0);
    tick();
    tick();
    fbw_row_rdy = 1'b0;
    for (int i = 0; i < 64; i++) send(24'h100 + 24'(i), 1'b0);
    tick();
    chk("prereset_row", {27'd0, fbw_row_addr}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_row",   {27'd0, fbw_row_addr}, 32'd0);
    chk("arst_data",  {8'd0, fbw_data}, 32'd0);
    chk("arst_col",   {26'd0, fbw_col_addr}, 32'd0);
    chk("arst_wren",  {31'd0, fbw_wren}, 32'd0);
    tick();
    rst = 1'b0;
    store_cnt = 0;
    chk_order = 1'b1;
    fbw_row_rdy = 1'b1;
    send(24'hABCDEF, 1'b0);
    chk("postrst_col",  {26'd0, fbw_col_addr}, 32'd0);
    chk("postrst_wren", {31'd0, fbw_wren}, 32'd1);
    for (int i = 1; i < 64; i++) send(24'(i), 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("postrst_store_cnt", store_cnt, 32'd1);
    chk("postrst_store_addr", {26'd0, last_bank, last_row}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
